spi_target: RTL

SPI_TARGET -- requirements
Module: spi_target

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sync_edge.sv | 41 ++++
 rtl/spi_target.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and default constants for the SPI target.
//   spi_state_e             : FSM state (IDLE / SHIFT)
//   SPI_DATA_WIDTH_DEFAULT  : default bits per SPI word
//   SPI_SYNC_STAGES_DEFAULT : default synchronizer depth on the SPI inputs
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  localparam int SPI_DATA_WIDTH_DEFAULT  = 8;
  localparam int SPI_SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer followed by an edge detector for
// one asynchronous SPI input.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   din_i   : raw asynchronous input
//   level_o : synchronized level
//   rise_o  : one-cycle pulse on a synchronized rising edge
//   fall_o  : one-cycle pulse on a synchronized falling edge
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Everything resets low. For chip select this means a cs_n already held
  // low when reset releases produces no falling edge, so a new frame only
  // starts on a genuinely fresh falling edge; cs_n high merely shows up as
  // a rising edge, which is harmless while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target (CPOL=0, CPHA=0), MSB first, oversampled
// in the system clock domain (f_sclk up to f_clk/8).
//   clk, rst            : system clock, asynchronous active-high reset
//   spi_sclk/cs_n/mosi  : SPI inputs from the initiator (asynchronous)
//   spi_miso            : SPI data to the initiator
//   spi_miso_oe         : MISO output enable (only with SPI_TARGET_MISO_OE_EN)
//   tx_data/tx_valid    : word offered to the one-deep holding register
//   tx_ready            : holding register empty
//   rx_data/rx_valid    : last complete received word, one-cycle strobe
// Build option: define SPI_TARGET_MISO_OE_EN to add spi_miso_oe and
// tristate spi_miso outside a frame; otherwise spi_miso is driven 0 in IDLE.
module spi_target
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
`ifdef SPI_TARGET_MISO_OE_EN
  output logic                  spi_miso_oe,
`endif
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Synchronized inputs and edges
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .din_i(spi_sclk),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .din_i(spi_cs_n),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .din_i(spi_mosi),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  // Only edges of sclk/cs_n and the level of mosi carry information.
  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

  // State
  spi_state_e            state_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] rx_shift_q;
  logic [DATA_WIDTH-1:0] rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  hold_full_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  miso_q;
  logic [DATA_WIDTH-1:0] load_word;
  logic                  accept;

  assign rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_lvl};
  // A load takes the holding register only if it was already full; a word
  // accepted in the same cycle lands in the holding register instead.
  assign load_word  = hold_full_q ? hold_q : '0;
  assign accept     = tx_valid && !hold_full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;

      // accept and a load are mutually exclusive on hold_full_q, so these
      // two writes never collide.
      if (accept) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            state_q    <= SHIFT;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            // MSB goes straight to MISO; the register keeps the rest.
            miso_q     <= load_word[DATA_WIDTH-1];
            tx_shift_q <= load_word << 1;
            if (hold_full_q) hold_full_q <= 1'b0;
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            // Partial word is dropped; holding register is left alone.
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            miso_q     <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift_q <= rx_shift_d;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q  <= '0;
              rx_data_q  <= rx_shift_d;
              rx_valid_q <= 1'b1;
              // The old word's LSB must stay on MISO until the next sclk
              // falling edge, so the reload is kept unshifted here and its
              // MSB is presented by that falling edge.
              tx_shift_q <= load_word;
              if (hold_full_q) hold_full_q <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end else if (sclk_fall) begin
            miso_q     <= tx_shift_q[DATA_WIDTH-1];
            tx_shift_q <= tx_shift_q << 1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready = !hold_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef SPI_TARGET_MISO_OE_EN
  assign spi_miso_oe = (state_q == SHIFT);
  assign spi_miso    = spi_miso_oe ? miso_q : 1'bz;
`else
  assign spi_miso    = miso_q;
`endif

endmodule
